// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_t   : receiver FSM states
//   clks_per_bit : clock cycles per serial bit (integer divide)
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
//   clk, rst : clock, synchronous active-high reset
//   push,din : write request and data; accepted when not full, or when full with a pop
//   full_c   : combinational full flag (from the occupancy register)
//   pop      : read request; ignored while valid=0
//   dout     : registered head entry; stable while nothing is popped
//   valid    : registered not-empty flag
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full_c,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pop_ok;
    logic             push_ok;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] head_nxt;

    assign full_c = (count == CNT_W'(DEPTH));

    // Handshake qualification, next pointers and the next head value.
    always_comb begin
        pop_ok    = pop & valid;
        push_ok   = push & (~full_c | pop_ok);
        rd_nxt    = rd_ptr + PTR_W'(pop_ok);
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        head_nxt  = dout;
        // A push into a queue that is (or becomes) empty bypasses straight to the head.
        if (push_ok && (count == CNT_W'(pop_ok))) begin
            head_nxt = din;
        end else if (count_nxt != '0) begin
            head_nxt = mem[rd_nxt];
        end
    end

    // Storage array; no reset needed, only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + PTR_W'(push_ok);
            count  <= count_nxt;
            dout   <= head_nxt;
            valid  <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small receive FIFO behind a valid/ready port.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx        : serial line, idle high, asynchronous to clk
//   data      : head-of-FIFO byte, meaningful while valid=1
//   valid     : FIFO not empty
//   ready     : consumer accepts data on a cycle with valid & ready
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned IDX_W = $clog2(BYTE_W);

    logic              rx_meta;
    logic              rx_s;

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_nxt;
    logic              frame_err_nxt;
    logic              overrun_nxt;
    logic              push_c;
    logic              pop_c;
    logic              full_c;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    assign pop_c = valid & ready;

    // Next-state and per-frame decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_W'(1);
        idx_nxt       = idx;
        shift_nxt     = shift;
        push_c        = 1'b0;
        frame_err_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject short glitches.
                if (cnt == CNT_W'(CPB / 2 - 1)) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == IDX_W'(BYTE_W - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push_c    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start bit counts.
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A push into a full FIFO only survives if the consumer pops that cycle.
        overrun_nxt = push_c & full_c & ~pop_c;
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_c),
        .din    (shift_nxt),
        .full_c (full_c),
        .pop    (pop_c),
        .dout   (data),
        .valid  (valid)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at default parameters (434 clocks per bit).
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 434;
    localparam int unsigned DEPTH = 4;
    // Line start edge to first cycle with valid high, including sync latency.
    localparam int unsigned LAT   = 4126;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int unsigned rise_q[$];
    int          fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0;
    int          fe_exp = 0, ov_exp = 0, occ = 0;
    logic        valid_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge: delivered bytes, valid rises, pulse counts.
    always @(negedge clk) begin
        if (valid && ready) got_q.push_back(data);
        if (valid && !valid_q) rise_q.push_back(cyc);
        if (frame_err) fe_cycles++;
        if (frame_err && !fe_q) fe_pulses++;
        if (overrun) ov_cycles++;
        if (overrun && !ov_q) ov_pulses++;
        valid_q = valid;
        fe_q    = frame_err;
        ov_q    = overrun;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame; stop selects a good (1) or bad (0) stop bit. Line left high.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
        t0 = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    // Reference: what the receiver should do with a frame given the consumer state.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) begin
            fe_exp++;
        end else if (!ready && occ == DEPTH) begin
            ov_exp++;
        end else begin
            exp_q.push_back(b);
            if (!ready) occ++;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " fe_pulses"}, fe_pulses, fe_exp);
        check({tag, " fe_width"}, fe_cycles, fe_exp);
        check({tag, " ov_pulses"}, ov_pulses, ov_exp);
        check({tag, " ov_width"}, ov_cycles, ov_exp);
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        fe_pulses = 0; fe_cycles = 0; ov_pulses = 0; ov_cycles = 0;
        fe_exp = 0; ov_exp = 0; occ = 0;
    endtask

    initial begin
        int unsigned t0a, t0b, t;
        logic [7:0]  b;
        logic        stop;

        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b1;
        tick(1);

        // Reset holds everything quiet.
        for (int i = 0; i < 30; i++) begin
            check("reset valid", valid, 1'b0);
            check("reset frame_err", frame_err, 1'b0);
            check("reset overrun", overrun, 1'b0);
            tick(1);
        end
        check("reset data", data, 8'h00);
        rst = 1'b0;
        tick(10);

        // Two back-to-back frames with receive latency.
        send_frame(8'hA5, 1'b1, t0a);
        model_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1, t0b);
        model_frame(8'h3C, 1'b1);
        tick(600);
        check("b2b rises", rise_q.size(), 2);
        if (rise_q.size() >= 2) begin
            t = rise_q[0] - t0a;
            check("lat A5", (t >= LAT - 2 && t <= LAT + 2), 1'b1);
            t = rise_q[1] - t0b;
            check("lat 3C", (t >= LAT - 2 && t <= LAT + 2), 1'b1);
        end
        check_stream("b2b");

        // Short low glitch: rejected silently.
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(1000);
        check_stream("glitch");

        // Bad stop bit, then a good frame.
        send_frame(8'h55, 1'b0, t);
        model_frame(8'h55, 1'b0);
        tick(20);
        send_frame(8'h12, 1'b1, t);
        model_frame(8'h12, 1'b1);
        tick(600);
        check_stream("framing");

        // Consumer stalled: fifth byte overruns, head stays put.
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, t);
            model_frame(b, 1'b1);
        end
        tick(600);
        check("stall nothing popped", got_q.size(), 0);
        check("stall valid", valid, 1'b1);
        check("stall head", data, 8'h01);
        check("stall overrun", ov_pulses, 1);
        ready = 1'b1;
        occ = 0;
        tick(20);
        check_stream("overrun");

        // Reset in the middle of a frame discards it.
        rx = 1'b0;
        tick(3 * CPB);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        check("midrst valid", valid, 1'b0);
        rst = 1'b0;
        tick(10);
        send_frame(8'h81, 1'b1, t);
        model_frame(8'h81, 1'b1);
        tick(600);
        check_stream("midrst");

        // Random bytes with occasional bad stop bits.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, t);
            model_frame(b, stop);
            tick(stop ? $urandom_range(1, 40) : $urandom_range(10, 40));
        end
        tick(600);
        check_stream("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
